trap_controller: RTL and testbench

Sequences machine-mode trap entry and return around the exception unit and the pipeline.
- Arbitrates synchronous exceptions from the exception unit against software, timer and external interrupts.
- Drains to a precise instruction boundary, commits mepc/mcause/mstatus, and drives a fetch redirect through a valid/ready handshake.
- Handles MRET.
- Sits beside the exception unit at the memory stage; owns mepc, mcause, mstatus.MIE and mstatus.MPIE.

---
 rtl/common_types_pkg.sv | 33 +++
 rtl/irq_synchronizer.sv | 24 ++
 rtl/trap_controller.sv | 189 ++++++++++++++++++
 tb/tb_trap_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared types and cause encodings for the machine-mode trap controller.
package common_types_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
  localparam logic [3:0] CAUSE_MSI          = 4'd3;
  localparam logic [3:0] CAUSE_MTI          = 4'd7;
  localparam logic [3:0] CAUSE_MEI          = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // pend is {MEI,MTI,MSI}; priority order is MEI, then MSI, then MTI.
  function automatic logic [3:0] irq_cause_idx(input logic [2:0] pend);
    logic [3:0] idx;
    if (pend[2]) begin
      idx = CAUSE_MEI;
    end else if (pend[0]) begin
      idx = CAUSE_MSI;
    end else if (pend[1]) begin
      idx = CAUSE_MTI;
    end else begin
      idx = 4'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_synchronizer.sv
// Multi-flop synchronizer bringing the asynchronous external interrupt into clk.
module irq_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain; only the last stage is safe to consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: arbitrates exceptions and interrupts,
// drains to a precise boundary, commits mepc/mcause/mstatus and redirects fetch.
module trap_controller
  import common_types_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic            sw_irq,
  input  logic [2:0]      mie_en,
  input  logic [XLEN-1:0] mtvec_base,
  input  logic [1:0]      mtvec_mode,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_valid,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            csr_mstatus_we,
  input  logic [1:0]      csr_mstatus_wdata,
  input  logic            csr_mepc_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            fetch_hold,
  output logic            flush_all,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            trap_taken,
  output logic [2:0]      mip,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic            mstatus_mie,
  output logic            mstatus_mpie
);

  trap_state_t     state_q, state_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;

  logic            ext_sync_s;
  logic [2:0]      pending_s;
  logic [XLEN-1:0] irq_mcause_s;
  logic [XLEN-1:0] irq_target_s;
  logic            commit_s;

  irq_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ext_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(ext_irq),
    .sync_o (ext_sync_s)
  );

  assign mip          = {ext_sync_s, timer_irq, sw_irq};
  assign pending_s    = mip & mie_en & {3{mie_q}};
  assign irq_mcause_s = {1'b1, {(XLEN-5){1'b0}}, cause_q};
  assign irq_target_s = (mtvec_mode == MTVEC_VECTORED)
                      ? mtvec_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00}
                      : mtvec_base;

  // Next-state, CSR commit and handshake outputs.
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    target_d       = target_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mie_d          = mie_q;
    mpie_d         = mpie_q;
    commit_s       = 1'b0;
    fetch_hold     = 1'b0;
    flush_all      = 1'b0;
    trap_taken     = 1'b0;
    redirect_valid = 1'b0;

    case (state_q)
      RUN, DRAIN: begin
        fetch_hold = (state_q == DRAIN);
        if (exc_valid) begin
          commit_s   = 1'b1;
          trap_taken = 1'b1;
          flush_all  = 1'b1;
          mepc_d     = exc_pc;
          mcause_d   = exc_cause;
          mpie_d     = mie_q;
          mie_d      = 1'b0;
          target_d   = mtvec_base;
          state_d    = REDIRECT;
        end else if (mret_valid) begin
          commit_s  = 1'b1;
          flush_all = 1'b1;
          mie_d     = mpie_q;
          mpie_d    = 1'b1;
          target_d  = mepc_q;
          state_d   = REDIRECT;
        end else if (state_q == RUN) begin
          if (|pending_s) begin
            fetch_hold = 1'b1;
            cause_d    = irq_cause_idx(pending_s);
            state_d    = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else if (~|pending_s) begin
          state_d = RUN;
        end else if (mem_valid) begin
          // The memory-stage instruction is squashed and replayed after mret.
          commit_s   = 1'b1;
          trap_taken = 1'b1;
          flush_all  = 1'b1;
          mepc_d     = mem_pc;
          mcause_d   = irq_mcause_s;
          mpie_d     = mie_q;
          mie_d      = 1'b0;
          target_d   = irq_target_s;
          state_d    = REDIRECT;
        end else begin
          state_d = DRAIN;
        end
      end
      REDIRECT: begin
        fetch_hold     = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_d = RUN;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A trap or mret commit in the same cycle overrides software CSR writes.
    if (!commit_s) begin
      if (csr_mstatus_we) begin
        mpie_d = csr_mstatus_wdata[1];
        mie_d  = csr_mstatus_wdata[0];
      end else begin
        mpie_d = mpie_d;
      end
      if (csr_mepc_we) begin
        mepc_d = csr_wdata;
      end else begin
        mepc_d = mepc_d;
      end
    end else begin
      commit_s = 1'b1;
    end
  end

  // State and architectural CSR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cause_q  <= 4'd0;
      target_q <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  assign redirect_pc  = target_q;
  assign mepc         = mepc_q;
  assign mcause       = mcause_q;
  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus a randomized
// run against a behavioural model of the trap rules.
module tb_trap_controller;

  localparam int XLEN = 32;
  localparam int P_RUN = 0, P_DRAIN = 1, P_REDIR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ext_irq, timer_irq, sw_irq;
  logic [2:0]      mie_en;
  logic [XLEN-1:0] mtvec_base;
  logic [1:0]      mtvec_mode;
  logic            exc_valid;
  logic [XLEN-1:0] exc_cause, exc_pc;
  logic            mret_valid, mem_valid;
  logic [XLEN-1:0] mem_pc;
  logic            csr_mstatus_we;
  logic [1:0]      csr_mstatus_wdata;
  logic            csr_mepc_we;
  logic [XLEN-1:0] csr_wdata;
  logic            fetch_hold, flush_all, redirect_valid, redirect_ready, trap_taken;
  logic [XLEN-1:0] redirect_pc, mepc, mcause;
  logic [2:0]      mip;
  logic            mstatus_mie, mstatus_mpie;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trap_controller #(.XLEN(XLEN), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
    .mie_en(mie_en), .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .csr_mstatus_we(csr_mstatus_we), .csr_mstatus_wdata(csr_mstatus_wdata),
    .csr_mepc_we(csr_mepc_we), .csr_wdata(csr_wdata),
    .fetch_hold(fetch_hold), .flush_all(flush_all), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .trap_taken(trap_taken),
    .mip(mip), .mepc(mepc), .mcause(mcause), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_valid = 1'b0; exc_cause = 32'h0; exc_pc = 32'h0;
    mret_valid = 1'b0; mem_valid = 1'b0; mem_pc = 32'h0;
    csr_mstatus_we = 1'b0; csr_mstatus_wdata = 2'b00;
    csr_mepc_we = 1'b0; csr_wdata = 32'h0; redirect_ready = 1'b0;
  endtask

  task automatic set_mstatus(input logic [1:0] v);
    csr_mstatus_we = 1'b1; csr_mstatus_wdata = v;
    tick();
    csr_mstatus_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
    mie_en = 3'b000; mtvec_base = 32'h800; mtvec_mode = 2'd0;
    tick(); tick();
    rst = 1'b0;
    #2;
    checks++; if (mepc !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%h exp=%h", mepc, 32'h0); end
    checks++; if (mcause !== 32'h0) begin failures++; $display("FAIL reset_mcause got=%h exp=%h", mcause, 32'h0); end
    checks++; if ({mstatus_mie, mstatus_mpie} !== 2'b00) begin failures++; $display("FAIL reset_mstatus got=%b exp=00", {mstatus_mie, mstatus_mpie}); end
    checks++; if ({fetch_hold, flush_all, trap_taken, redirect_valid} !== 4'b0000) begin failures++; $display("FAIL reset_outputs got=%b exp=0000", {fetch_hold, flush_all, trap_taken, redirect_valid}); end
    checks++; if (mip !== 3'b000) begin failures++; $display("FAIL reset_mip got=%b exp=000", mip); end
  endtask

  task automatic test_illegal_inst();
    set_mstatus(2'b01);
    exc_valid = 1'b1; exc_cause = 32'h2; exc_pc = 32'h100;
    #2;
    checks++; if (trap_taken !== 1'b1 || flush_all !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b%b exp=11", trap_taken, flush_all); end
    tick();
    exc_cause = 32'h5;
    #2;
    checks++; if (mepc !== 32'h100) begin failures++; $display("FAIL ill_mepc got=%h exp=%h", mepc, 32'h100); end
    checks++; if (mcause !== 32'h2) begin failures++; $display("FAIL ill_mcause got=%h exp=%h", mcause, 32'h2); end
    checks++; if ({mstatus_mie, mstatus_mpie} !== 2'b01) begin failures++; $display("FAIL ill_mstatus got=%b exp=01", {mstatus_mie, mstatus_mpie}); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h800) begin failures++; $display("FAIL ill_redirect_hold cyc=%0d got=%b/%h exp=1/%h", i, redirect_valid, redirect_pc, 32'h800); end
      checks++; if (trap_taken !== 1'b0) begin failures++; $display("FAIL ill_exc_in_redirect got=%b exp=0", trap_taken); end
      tick(); #2;
    end
    exc_valid = 1'b0; redirect_ready = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL ill_redirect_4th got=%b exp=1", redirect_valid); end
    tick();
    redirect_ready = 1'b0;
    #2;
    checks++; if (redirect_valid !== 1'b0 || fetch_hold !== 1'b0) begin failures++; $display("FAIL ill_back_to_run got=%b%b exp=00", redirect_valid, fetch_hold); end
    checks++; if (mepc !== 32'h100 || mcause !== 32'h2) begin failures++; $display("FAIL ill_ignored_exc got=%h/%h exp=100/2", mepc, mcause); end
  endtask

  task automatic test_vectored_timer();
    mtvec_mode = 2'd1; mie_en = 3'b010;
    set_mstatus(2'b01);
    timer_irq = 1'b1;
    #2;
    checks++; if (fetch_hold !== 1'b1) begin failures++; $display("FAIL vt_hold_run got=%b exp=1", fetch_hold); end
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      checks++; if (fetch_hold !== 1'b1 || trap_taken !== 1'b0) begin failures++; $display("FAIL vt_drain cyc=%0d got=%b%b exp=10", i, fetch_hold, trap_taken); end
    end
    tick();
    mem_valid = 1'b1; mem_pc = 32'h204;
    #2;
    checks++; if (trap_taken !== 1'b1 || flush_all !== 1'b1) begin failures++; $display("FAIL vt_commit got=%b%b exp=11", trap_taken, flush_all); end
    tick();
    mem_valid = 1'b0; timer_irq = 1'b0;
    #2;
    checks++; if (mepc !== 32'h204) begin failures++; $display("FAIL vt_mepc got=%h exp=%h", mepc, 32'h204); end
    checks++; if (mcause !== 32'h80000007) begin failures++; $display("FAIL vt_mcause got=%h exp=%h", mcause, 32'h80000007); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h81C) begin failures++; $display("FAIL vt_target got=%b/%h exp=1/%h", redirect_valid, redirect_pc, 32'h81C); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
  endtask

  task automatic test_priority_exc_in_drain();
    mtvec_mode = 2'd1; mie_en = 3'b111;
    ext_irq = 1'b1; timer_irq = 1'b1; sw_irq = 1'b1;
    tick(); tick();
    #2;
    checks++; if (mip !== 3'b111) begin failures++; $display("FAIL pr_mip got=%b exp=111", mip); end
    checks++; if (fetch_hold !== 1'b0) begin failures++; $display("FAIL pr_masked got=%b exp=0", fetch_hold); end
    set_mstatus(2'b01);
    #2;
    checks++; if (fetch_hold !== 1'b1) begin failures++; $display("FAIL pr_hold got=%b exp=1", fetch_hold); end
    tick();
    exc_valid = 1'b1; exc_cause = 32'h2; exc_pc = 32'h400;
    #2;
    checks++; if (trap_taken !== 1'b1) begin failures++; $display("FAIL pr_exc_drain got=%b exp=1", trap_taken); end
    tick();
    exc_valid = 1'b0;
    #2;
    checks++; if (mcause !== 32'h2 || mepc !== 32'h400) begin failures++; $display("FAIL pr_exc_csr got=%h/%h exp=2/400", mcause, mepc); end
    checks++; if (redirect_pc !== 32'h800) begin failures++; $display("FAIL pr_exc_target got=%h exp=%h", redirect_pc, 32'h800); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    set_mstatus(2'b01);
    #2;
    checks++; if (fetch_hold !== 1'b1) begin failures++; $display("FAIL pr_rearm got=%b exp=1", fetch_hold); end
    tick();
    mem_valid = 1'b1; mem_pc = 32'h500;
    #2;
    checks++; if (trap_taken !== 1'b1) begin failures++; $display("FAIL pr_irq_commit got=%b exp=1", trap_taken); end
    tick();
    mem_valid = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
    #2;
    checks++; if (mcause !== 32'h8000000B || mepc !== 32'h500) begin failures++; $display("FAIL pr_mei_csr got=%h/%h exp=8000000b/500", mcause, mepc); end
    checks++; if (redirect_pc !== 32'h82C) begin failures++; $display("FAIL pr_mei_target got=%h exp=%h", redirect_pc, 32'h82C); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_irq_drop();
    mtvec_mode = 2'd0; mie_en = 3'b010;
    set_mstatus(2'b01);
    timer_irq = 1'b1;
    #2;
    checks++; if (fetch_hold !== 1'b1) begin failures++; $display("FAIL drop_hold got=%b exp=1", fetch_hold); end
    tick();
    timer_irq = 1'b0; mem_valid = 1'b1; mem_pc = 32'h600;
    #2;
    checks++; if (trap_taken !== 1'b0 || flush_all !== 1'b0 || fetch_hold !== 1'b1) begin failures++; $display("FAIL drop_no_trap got=%b%b%b exp=001", trap_taken, flush_all, fetch_hold); end
    tick();
    mem_valid = 1'b0;
    #2;
    checks++; if (fetch_hold !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL drop_run got=%b%b exp=00", fetch_hold, redirect_valid); end
    checks++; if (mepc !== 32'h500 || mstatus_mie !== 1'b1) begin failures++; $display("FAIL drop_csr got=%h/%b exp=500/1", mepc, mstatus_mie); end
  endtask

  task automatic test_mret();
    mie_en = 3'b000;
    csr_mstatus_we = 1'b1; csr_mstatus_wdata = 2'b10;
    csr_mepc_we = 1'b1; csr_wdata = 32'h300;
    tick();
    csr_mstatus_we = 1'b0; csr_mepc_we = 1'b0;
    #2;
    checks++; if (mepc !== 32'h300 || {mstatus_mie, mstatus_mpie} !== 2'b01) begin failures++; $display("FAIL mret_setup got=%h/%b exp=300/01", mepc, {mstatus_mie, mstatus_mpie}); end
    mret_valid = 1'b1;
    csr_mstatus_we = 1'b1; csr_mstatus_wdata = 2'b00;
    csr_mepc_we = 1'b1; csr_wdata = 32'h999;
    #1;
    checks++; if (flush_all !== 1'b1 || trap_taken !== 1'b0) begin failures++; $display("FAIL mret_pulse got=%b%b exp=10", flush_all, trap_taken); end
    tick();
    mret_valid = 1'b0; csr_mstatus_we = 1'b0; csr_mepc_we = 1'b0;
    #2;
    checks++; if ({mstatus_mie, mstatus_mpie} !== 2'b11) begin failures++; $display("FAIL mret_mstatus got=%b exp=11", {mstatus_mie, mstatus_mpie}); end
    checks++; if (mepc !== 32'h300) begin failures++; $display("FAIL mret_mepc_kept got=%h exp=%h", mepc, 32'h300); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin failures++; $display("FAIL mret_target got=%b/%h exp=1/%h", redirect_valid, redirect_pc, 32'h300); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] m_mepc, m_mcause, m_target, n_mepc, n_mcause;
    logic        m_mie, m_mpie, n_mie, n_mpie, e1, e2, commit;
    logic [2:0]  m_mip, m_pend;
    logic        x_hold, x_flush, x_trap, x_rv;
    int          m_phase, m_cause, hi;

    rst = 1'b1; idle_inputs();
    ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0; mie_en = 3'b000;
    tick();
    rst = 1'b0;
    m_mepc = 32'h0; m_mcause = 32'h0; m_target = 32'h0;
    m_mie = 1'b0; m_mpie = 1'b0; e1 = 1'b0; e2 = 1'b0;
    m_phase = P_RUN; m_cause = 0;

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 5) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 5) == 0) sw_irq = ~sw_irq;
      if ($urandom_range(0, 19) == 0) mie_en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) mtvec_base = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 29) == 0) mtvec_mode = 2'($urandom_range(0, 1));
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_cause = 32'($urandom_range(0, 15)); exc_pc = $urandom;
      mret_valid = ($urandom_range(0, 11) == 0);
      mem_valid = ($urandom_range(0, 2) == 0); mem_pc = $urandom;
      csr_mstatus_we = ($urandom_range(0, 7) == 0); csr_mstatus_wdata = 2'($urandom_range(0, 3));
      csr_mepc_we = ($urandom_range(0, 11) == 0); csr_wdata = $urandom;
      redirect_ready = ($urandom_range(0, 1) == 1);
      #2;

      m_mip  = {e2, timer_irq, sw_irq};
      m_pend = m_mip & mie_en & (m_mie ? 3'b111 : 3'b000);
      hi = m_pend[2] ? 11 : (m_pend[0] ? 3 : (m_pend[1] ? 7 : 0));
      x_hold = (m_phase != P_RUN); x_flush = 1'b0; x_trap = 1'b0; x_rv = (m_phase == P_REDIR);
      n_mepc = m_mepc; n_mcause = m_mcause; n_mie = m_mie; n_mpie = m_mpie; commit = 1'b0;
      if (m_phase == P_REDIR) begin
        if (redirect_ready) m_phase = P_RUN;
      end else if (exc_valid) begin
        x_trap = 1'b1; x_flush = 1'b1; commit = 1'b1;
        n_mepc = exc_pc; n_mcause = exc_cause; n_mpie = m_mie; n_mie = 1'b0;
        m_target = mtvec_base; m_phase = P_REDIR;
      end else if (mret_valid) begin
        x_flush = 1'b1; commit = 1'b1;
        n_mie = m_mpie; n_mpie = 1'b1; m_target = m_mepc; m_phase = P_REDIR;
      end else if (m_phase == P_RUN) begin
        if (hi != 0) begin x_hold = 1'b1; m_cause = hi; m_phase = P_DRAIN; end
      end else if (hi == 0) begin
        m_phase = P_RUN;
      end else if (mem_valid) begin
        x_trap = 1'b1; x_flush = 1'b1; commit = 1'b1;
        n_mepc = mem_pc; n_mcause = 32'h8000_0000 + 32'(m_cause);
        n_mpie = m_mie; n_mie = 1'b0;
        m_target = (mtvec_mode == 2'd1) ? mtvec_base + 32'(m_cause * 4) : mtvec_base;
        m_phase = P_REDIR;
      end
      if (!commit && csr_mstatus_we) begin n_mpie = csr_mstatus_wdata[1]; n_mie = csr_mstatus_wdata[0]; end
      if (!commit && csr_mepc_we) n_mepc = csr_wdata;

      checks++; if (mip !== m_mip) begin failures++; $display("FAIL rnd_mip cyc=%0d got=%b exp=%b", n, mip, m_mip); end
      checks++; if ({fetch_hold, flush_all, trap_taken, redirect_valid} !== {x_hold, x_flush, x_trap, x_rv}) begin failures++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", n, {fetch_hold, flush_all, trap_taken, redirect_valid}, {x_hold, x_flush, x_trap, x_rv}); end
      if (x_rv) begin
        checks++; if (redirect_pc !== m_target) begin failures++; $display("FAIL rnd_redirect_pc cyc=%0d got=%h exp=%h", n, redirect_pc, m_target); end
      end

      m_mepc = n_mepc; m_mcause = n_mcause; m_mie = n_mie; m_mpie = n_mpie;
      e2 = e1; e1 = ext_irq;
      tick();

      checks++; if (mepc !== m_mepc || mcause !== m_mcause) begin failures++; $display("FAIL rnd_csr cyc=%0d got=%h/%h exp=%h/%h", n, mepc, mcause, m_mepc, m_mcause); end
      checks++; if ({mstatus_mie, mstatus_mpie} !== {m_mie, m_mpie}) begin failures++; $display("FAIL rnd_mstatus cyc=%0d got=%b exp=%b", n, {mstatus_mie, mstatus_mpie}, {m_mie, m_mpie}); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_redirect();
    rst = 1'b1; idle_inputs();
    ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0; mie_en = 3'b000;
    mtvec_base = 32'h800; mtvec_mode = 2'd0;
    tick();
    rst = 1'b0;
    exc_valid = 1'b1; exc_cause = 32'h2; exc_pc = 32'h700;
    tick();
    exc_valid = 1'b0;
    #2;
    checks++; if (redirect_valid !== 1'b1 || mepc !== 32'h700) begin failures++; $display("FAIL rr_in_redirect got=%b/%h exp=1/700", redirect_valid, mepc); end
    ext_irq = 1'b1; rst = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b0 || fetch_hold !== 1'b0) begin failures++; $display("FAIL rr_async_drop got=%b%b exp=00", redirect_valid, fetch_hold); end
    checks++; if (mepc !== 32'h0 || mcause !== 32'h0) begin failures++; $display("FAIL rr_csr_clear got=%h/%h exp=0/0", mepc, mcause); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (mip !== 3'b000) begin failures++; $display("FAIL rr_mip_0 got=%b exp=000", mip); end
    tick();
    checks++; if (mip[2] !== 1'b0) begin failures++; $display("FAIL rr_mip_1edge got=%b exp=0", mip[2]); end
    tick();
    checks++; if (mip[2] !== 1'b1) begin failures++; $display("FAIL rr_mip_2edge got=%b exp=1", mip[2]); end
    checks++; if (fetch_hold !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL rr_run got=%b%b exp=00", fetch_hold, redirect_valid); end
  endtask

  initial begin
    test_reset();
    test_illegal_inst();
    test_vectored_timer();
    test_priority_exc_in_drain();
    test_irq_drop();
    test_mret();
    test_random();
    test_reset_mid_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
